// File: rtl/rotate_ctrl_if.sv
// Button inputs and display-driver control outputs of rotate_ctrl.
// The design takes the slave side; whoever drives the buttons takes the master side.
interface rotate_ctrl_if;
    logic btn_run;
    logic btn_dir;
    logic en;
    logic cw;
    logic step;

    modport master (
        output btn_run,
        output btn_dir,
        input  en,
        input  cw,
        input  step
    );

    modport slave (
        input  btn_run,
        input  btn_dir,
        output en,
        output cw,
        output step
    );
endinterface

// File: rtl/rotate_ctrl.sv
// Run/stop and direction control for the rotating-segment display driver:
// button synchronizer + debounce, run/stop FSM, step prescaler, direction updates held to step edges.
module rotate_ctrl #(
    parameter int unsigned TICK_DIV  = 25_000_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         reset,
    rotate_ctrl_if.slave bus
);

    localparam int unsigned DcW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DcW-1:0]  DcMax  = DcW'(DB_CYCLES - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    typedef enum logic {StStop, StRun} state_e;

    // Index 0 is the run/stop button, index 1 the direction button.
    logic [1:0]     raw;
    logic [1:0]     sync1_q, s_q;
    logic [1:0]     db_q, db_d, dbp_q, press_q;
    logic [DcW-1:0] dc_q [2];
    logic [DcW-1:0] dc_d [2];

    assign raw = {bus.btn_dir, bus.btn_run};

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            db_d[b] = db_q[b];
            dc_d[b] = dc_q[b];
            if (s_q[b] == db_q[b]) begin
                dc_d[b] = '0;
            end else if (dc_q[b] == DcMax) begin
                db_d[b] = s_q[b];
                dc_d[b] = '0;
            end else begin
                dc_d[b] = dc_q[b] + DcW'(1);
            end
        end
    end

    // Press pulse is registered once more so the FSM reacts DB_CYCLES+3 edges after sampling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            s_q     <= '0;
            db_q    <= '0;
            dbp_q   <= '0;
            press_q <= '0;
            for (int b = 0; b < 2; b++) begin
                dc_q[b] <= '0;
            end
        end else begin
            sync1_q <= raw;
            s_q     <= sync1_q;
            db_q    <= db_d;
            dbp_q   <= db_q;
            press_q <= db_q & ~dbp_q;
            for (int b = 0; b < 2; b++) begin
                dc_q[b] <= dc_d[b];
            end
        end
    end

    logic run_press, dir_press;
    assign run_press = press_q[0];
    assign dir_press = press_q[1];

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            en_q, en_d;
    logic            cw_q, cw_d;
    logic            step_q, step_d;
    logic            pend_q, pend_d;
    logic            pend_next;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = 1'b0;
        cw_d      = cw_q;
        pend_d    = pend_q;
        pend_next = pend_q ^ dir_press;
        unique case (state_q)
            StStop: begin
                cnt_d  = '0;
                pend_d = 1'b0;
                if (dir_press) begin
                    cw_d = ~cw_q;
                end
                if (run_press) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (run_press) begin
                    state_d = StStop;
                    cnt_d   = '0;
                    cw_d    = cw_q ^ pend_next;
                    pend_d  = 1'b0;
                end else if (cnt_q == CntMax) begin
                    step_d = 1'b1;
                    cnt_d  = '0;
                    cw_d   = cw_q ^ pend_next;
                    pend_d = 1'b0;
                end else begin
                    cnt_d  = cnt_q + CntW'(1);
                    pend_d = pend_next;
                end
            end
            default: begin
                state_d = StStop;
            end
        endcase
        en_d = (state_d == StRun);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StStop;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            cw_q    <= 1'b1;
            step_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            cw_q    <= cw_d;
            step_q  <= step_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.en   = en_q;
    assign bus.cw   = cw_q;
    assign bus.step = step_q;

endmodule

// File: tb/tb_rotate_ctrl.sv
// Bench for rotate_ctrl: directed scenarios with literal timing plus random buttons
// compared every cycle against an event-level model.
module tb_rotate_ctrl;

    localparam int unsigned TickDiv  = 4;
    localparam int unsigned DbCycles = 3;
    localparam int SigEn = 0, SigCw = 1, SigStep = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rotate_ctrl_if bus ();

    rotate_ctrl #(
        .TICK_DIV (TickDiv),
        .DB_CYCLES(DbCycles)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: raw samples age two edges, a level is adopted after DbCycles straight
    // differing samples, and each adopted rise acts on the control two edges later.
    bit m_h0[2], m_h1[2], m_db[2], m_d0[2], m_d1[2];
    int m_diff[2];
    bit m_raw[2], m_eff[2];
    bit m_run, m_cw, m_step, m_pend, m_pnow, m_s, m_rise;
    int m_phase;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                m_h0[b] = 0; m_h1[b] = 0; m_db[b] = 0; m_d0[b] = 0; m_d1[b] = 0;
                m_diff[b] = 0;
            end
            m_run = 0; m_cw = 1; m_step = 0; m_pend = 0; m_phase = 0;
        end else begin
            m_raw[0] = bus.btn_run;
            m_raw[1] = bus.btn_dir;
            for (int b = 0; b < 2; b++) begin
                m_s = m_h1[b];
                m_h1[b] = m_h0[b];
                m_h0[b] = m_raw[b];
                m_rise = 0;
                if (m_s != m_db[b]) begin
                    m_diff[b]++;
                    if (m_diff[b] == DbCycles) begin
                        m_db[b] = m_s;
                        m_diff[b] = 0;
                        m_rise = m_s;
                    end
                end else begin
                    m_diff[b] = 0;
                end
                m_eff[b] = m_d1[b];
                m_d1[b] = m_d0[b];
                m_d0[b] = m_rise;
            end
            m_step = 0;
            if (!m_run) begin
                if (m_eff[1]) m_cw = !m_cw;
                if (m_eff[0]) begin
                    m_run = 1;
                    m_phase = 0;
                end
            end else begin
                m_pnow = m_pend ^ m_eff[1];
                if (m_eff[0]) begin
                    m_run = 0;
                    m_cw = m_cw ^ m_pnow;
                    m_pend = 0;
                end else if (m_phase + 1 == TickDiv) begin
                    m_step = 1;
                    m_phase = 0;
                    m_cw = m_cw ^ m_pnow;
                    m_pend = 0;
                end else begin
                    m_phase++;
                    m_pend = m_pnow;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started && !reset) begin
            check("model_en", int'(bus.en), int'(m_run));
            check("model_cw", int'(bus.cw), int'(m_cw));
            check("model_step", int'(bus.step), int'(m_step));
        end
    end

    function automatic logic sig(input int which);
        case (which)
            SigEn:   return bus.en;
            SigCw:   return bus.cw;
            default: return bus.step;
        endcase
    endfunction

    // start=-1 when called right after driving an input (counts edges from first sample),
    // start=0 when called at the observation of an event (counts edges since that event).
    task automatic edges_until(input int which, input logic val, input int start, output int n);
        n = start;
        do begin
            @(negedge clk);
            n++;
        end while (sig(which) !== val && n < 60);
    endtask

    int n;

    initial begin
        reset = 1'b1;
        bus.btn_run = 1'b0;
        bus.btn_dir = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_en", int'(bus.en), 0);
        check("rst_cw", int'(bus.cw), 1);
        check("rst_step", int'(bus.step), 0);
        reset = 1'b0;
        started = 1'b1;
        repeat (3) @(negedge clk);

        // Bounce shorter than the debounce window
        for (int i = 0; i < 4; i++) begin
            bus.btn_run = (i % 2 == 0);
            @(negedge clk);
        end
        bus.btn_run = 1'b0;
        repeat (15) @(negedge clk);
        check("bounce_en", int'(bus.en), 0);

        // Run press and step cadence
        bus.btn_run = 1'b1;
        edges_until(SigEn, 1'b1, -1, n);
        check("run_latency", n, 6);
        for (int k = 0; k < 3; k++) begin
            edges_until(SigStep, 1'b1, 0, n);
            check("step_period", n, 4);
            check("step_cw", int'(bus.cw), 1);
            if (k == 0) bus.btn_run = 1'b0;
        end

        // Single direction press in RUN lands on a step edge
        bus.btn_dir = 1'b1;
        repeat (4) @(negedge clk);
        bus.btn_dir = 1'b0;
        edges_until(SigCw, 1'b0, 0, n);
        check("dir_run_on_step", int'(bus.step), 1);
        check("dir_run_cw", int'(bus.cw), 0);
        repeat (10) @(negedge clk);

        // Run press arriving on the terminal-count cycle
        edges_until(SigStep, 1'b1, 0, n);
        @(negedge clk);
        bus.btn_run = 1'b1;
        edges_until(SigEn, 1'b0, -1, n);
        check("stop_latency", n, 6);
        check("stop_no_step", int'(bus.step), 0);
        bus.btn_run = 1'b0;
        repeat (10) @(negedge clk);

        // Re-entry: first step TickDiv edges after en rises
        bus.btn_run = 1'b1;
        edges_until(SigEn, 1'b1, -1, n);
        check("rerun_latency", n, 6);
        bus.btn_run = 1'b0;
        edges_until(SigStep, 1'b1, 0, n);
        check("rerun_first_step", n, 4);
        bus.btn_run = 1'b1;
        edges_until(SigEn, 1'b0, -1, n);
        bus.btn_run = 1'b0;
        repeat (10) @(negedge clk);

        // Direction press in STOP toggles cw (currently 0) directly
        bus.btn_dir = 1'b1;
        edges_until(SigCw, 1'b1, -1, n);
        check("dir_stop_latency", n, 6);
        check("dir_stop_en", int'(bus.en), 0);
        check("dir_stop_step", int'(bus.step), 0);
        bus.btn_dir = 1'b0;
        repeat (10) @(negedge clk);

        // Asynchronous reset mid-RUN with a direction press pending
        bus.btn_run = 1'b1;
        edges_until(SigEn, 1'b1, -1, n);
        bus.btn_run = 1'b0;
        repeat (8) @(negedge clk);
        bus.btn_dir = 1'b1;
        repeat (4) @(negedge clk);
        bus.btn_dir = 1'b0;
        repeat (5) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_rst_en", int'(bus.en), 0);
        check("async_rst_cw", int'(bus.cw), 1);
        check("async_rst_step", int'(bus.step), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_en", int'(bus.en), 0);
        check("post_rst_cw", int'(bus.cw), 1);

        // Random button activity with occasional resets
        for (int it = 0; it < 400; it++) begin
            bus.btn_run = ($urandom_range(0, 2) == 0);
            bus.btn_dir = ($urandom_range(0, 1) == 0);
            repeat ($urandom_range(1, 10)) @(negedge clk);
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        bus.btn_run = 1'b0;
        bus.btn_dir = 1'b0;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
